// File: rtl/therm_dac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : therm_dac_pkg                                                 |
// | Purpose  : Shared constants, FSM state type and level saturation helper  |
// |            for the binary-to-thermometer DAC driver.                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package therm_dac_pkg;

  localparam int NBITS   = 4;
  localparam int NLEVELS = (1 << NBITS) - 1;
  localparam int CNT_W   = 8;

  // Upper bound of a legal level, at the signed width used for step arithmetic.
  localparam logic signed [NBITS+1:0] LEVEL_MAX_S = (NBITS + 2)'(NLEVELS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLEW   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  // Clamp a signed intermediate level into 0..NLEVELS.
  function automatic logic [NBITS-1:0] sat_level(input logic signed [NBITS+1:0] v);
    logic [NBITS-1:0] r;
    if (v[NBITS+1]) begin
      r = '0;
    end else if (v > LEVEL_MAX_S) begin
      r = NBITS'(NLEVELS);
    end else begin
      r = v[NBITS-1:0];
    end
    return r;
  endfunction

endpackage : therm_dac_pkg
`default_nettype wire

// File: rtl/bin2therm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bin2therm                                                     |
// | Purpose  : Combinational binary to thermometer decoder.                  |
// |            therm[i] = (val > i).                                         |
// | Ports    : val   - binary value, NB bits                                 |
// |            therm - thermometer code, NL bits                             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bin2therm #(
  parameter int NB = 4,
  parameter int NL = (1 << NB) - 1
) (
  input  logic [NB-1:0] val,
  output logic [NL-1:0] therm
);

  for (genvar i = 0; i < NL; i++) begin : g_bit
    localparam logic [NB-1:0] IDX = NB'(i);
    assign therm[i] = (val > IDX);
  end

endmodule : bin2therm
`default_nettype wire

// File: rtl/therm_dac_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : therm_dac_driver                                              |
// | Purpose  : Accepts binary codes over valid/ready and drives a slew-      |
// |            limited thermometer bus to a unary current-steering DAC,      |
// |            followed by a settle window and a one-cycle settled pulse.    |
// | Ports    : clk        - clock, rising edge                               |
// |            rst        - synchronous active-high reset                    |
// |            code_valid - a code is offered                                |
// |            code       - target binary code 0..NLEVELS                    |
// |            code_ready - code accepted this cycle (IDLE and not in reset) |
// |            therm      - registered thermometer bus                       |
// |            level      - registered binary level (popcount of therm)      |
// |            busy       - state is not IDLE                                |
// |            settled    - one-cycle pulse after the settle window          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module therm_dac_driver
  import therm_dac_pkg::*;
#(
  parameter int STEP          = 1,   // 1..NLEVELS
  parameter int SETTLE_CYCLES = 2    // 0..255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               code_valid,
  input  logic [NBITS-1:0]   code,
  output logic               code_ready,
  output logic [NLEVELS-1:0] therm,
  output logic [NBITS-1:0]   level,
  output logic               busy,
  output logic               settled
);

  localparam logic [NBITS:0]   STEP_V   = (NBITS + 1)'(STEP);
  localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYCLES);

  state_t             state;
  logic [NBITS-1:0]   target;
  logic [CNT_W-1:0]   count;

  logic signed [NBITS:0]   diff;
  logic [NBITS:0]          mag;
  logic [NBITS:0]          step_amt;
  logic signed [NBITS+1:0] stepped;
  logic [NBITS-1:0]        level_nxt;
  logic [NLEVELS-1:0]      therm_nxt;

  // Step toward target by min(STEP, |target-level|); the clamp removes any
  // possibility of overshoot, saturation guards the representable range.
  always_comb begin
    diff     = $signed({1'b0, target}) - $signed({1'b0, level});
    mag      = diff[NBITS] ? $unsigned(-diff) : $unsigned(diff);
    step_amt = (mag < STEP_V) ? mag : STEP_V;
    if (diff[NBITS]) begin
      stepped = $signed({2'b00, level}) - $signed({1'b0, step_amt});
    end else begin
      stepped = $signed({2'b00, level}) + $signed({1'b0, step_amt});
    end
    level_nxt = (state == SLEW) ? sat_level(stepped) : level;
  end

  // therm is registered from the decode of the next level so that therm and
  // level always change on the same edge.
  bin2therm #(
    .NB (NBITS),
    .NL (NLEVELS)
  ) u_dec (
    .val   (level_nxt),
    .therm (therm_nxt)
  );

  assign code_ready = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      level   <= '0;
      therm   <= '0;
      target  <= '0;
      count   <= '0;
      settled <= 1'b0;
    end else begin
      settled <= 1'b0;
      level   <= level_nxt;
      therm   <= therm_nxt;
      case (state)
        IDLE: begin
          if (code_valid && code_ready) begin
            target <= code;
            if (code != level) begin
              state <= SLEW;
            end else begin
              state <= SETTLE;
              count <= SETTLE_V;
            end
          end
        end
        SLEW: begin
          if (level_nxt == target) begin
            state <= SETTLE;
            count <= SETTLE_V;
          end
        end
        SETTLE: begin
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            state   <= IDLE;
            settled <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : therm_dac_driver
`default_nettype wire

// File: tb/tb_therm_dac_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_therm_dac_driver                                           |
// | Purpose  : Self-checking bench for therm_dac_driver. Three instances     |
// |            cover STEP=1/SETTLE=2, STEP=4/SETTLE=2, STEP=15/SETTLE=0.     |
// |            Each accepted code is expanded into the full expected         |
// |            per-cycle trajectory (level, busy, settled).                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_therm_dac_driver;

  logic        clk;
  logic        rst;
  logic        cv  [3];
  logic [3:0]  cd  [3];
  logic        rdy [3];
  logic [14:0] th  [3];
  logic [3:0]  lv  [3];
  logic        bz  [3];
  logic        st  [3];

  int nassert = 0;
  int nfail   = 0;

  // Expected-trajectory queues: entry = level | busy<<8 | settled<<9
  int          q      [3][$];
  int          cur_lv [3];
  bit          cur_bz [3];
  bit          cur_st [3];
  bit          acc    [3];
  bit          acc_st [3];
  logic [14:0] prev_th[3];

  therm_dac_driver #(.STEP(1), .SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .code_valid(cv[0]), .code(cd[0]), .code_ready(rdy[0]),
    .therm(th[0]), .level(lv[0]), .busy(bz[0]), .settled(st[0]));

  therm_dac_driver #(.STEP(4), .SETTLE_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst), .code_valid(cv[1]), .code(cd[1]), .code_ready(rdy[1]),
    .therm(th[1]), .level(lv[1]), .busy(bz[1]), .settled(st[1]));

  therm_dac_driver #(.STEP(15), .SETTLE_CYCLES(0)) u_dut2 (
    .clk(clk), .rst(rst), .code_valid(cv[2]), .code(cd[2]), .code_ready(rdy[2]),
    .therm(th[2]), .level(lv[2]), .busy(bz[2]), .settled(st[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int step_of(input int k);
    case (k)
      0:       return 1;
      1:       return 4;
      default: return 15;
    endcase
  endfunction

  function automatic int settle_of(input int k);
    return (k == 2) ? 0 : 2;
  endfunction

  function automatic int enc(input int l, input int b, input int s);
    return l | (b << 8) | (s << 9);
  endfunction

  task automatic chk(input string tag, input int k, input int obs, input int exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s dut%0d: observed %0d expected %0d at %0t", tag, k, obs, exp, $time);
    end
  endtask

  // Transfer accepted at level 'from' toward 'to': one busy cycle at the old
  // level, one entry per step, SETTLE_CYCLES more busy cycles, then idle+settled.
  task automatic build(input int k, input int from, input int to);
    int l;
    int d;
    l = from;
    q[k].push_back(enc(l, 1, 0));
    while (l != to) begin
      d = to - l;
      if (d > step_of(k)) d = step_of(k);
      else if (d < -step_of(k)) d = -step_of(k);
      l = l + d;
      q[k].push_back(enc(l, 1, 0));
    end
    repeat (settle_of(k)) q[k].push_back(enc(to, 1, 0));
    q[k].push_back(enc(to, 0, 1));
  endtask

  task automatic tick();
    bit   xfer [3];
    int   code_s [3];
    bit   r;
    int   e;
    logic [14:0] exp_th;
    r = rst;
    for (int k = 0; k < 3; k++) begin
      xfer[k]   = cv[k] && !cur_bz[k] && !r;
      code_s[k] = int'(cd[k]);
      acc[k]    = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        q[k].delete();
        cur_lv[k] = 0;
        cur_bz[k] = 1'b0;
        cur_st[k] = 1'b0;
      end else begin
        if (xfer[k]) begin
          acc[k]    = 1'b1;
          acc_st[k] = cur_st[k];
          build(k, cur_lv[k], code_s[k]);
        end
        if (q[k].size() > 0) begin
          e = q[k].pop_front();
          cur_lv[k] = e & 8'hFF;
          cur_bz[k] = e[8];
          cur_st[k] = e[9];
        end else begin
          cur_bz[k] = 1'b0;
          cur_st[k] = 1'b0;
        end
      end
      exp_th = 15'((32'd1 << cur_lv[k]) - 32'd1);
      chk("level",      k, int'(lv[k]),  cur_lv[k]);
      chk("therm",      k, int'(th[k]),  int'(exp_th));
      chk("busy",       k, int'(bz[k]),  int'(cur_bz[k]));
      chk("settled",    k, int'(st[k]),  int'(cur_st[k]));
      chk("code_ready", k, int'(rdy[k]), int'(!cur_bz[k] && !rst));
      chk("therm_valid",k, int'((th[k] & (th[k] + 15'd1)) == 15'd0), 1);
      chk("popcount",   k, $countones(th[k]), int'(lv[k]));
      if (!r) chk("hamming_le_step", k, int'($countones(th[k] ^ prev_th[k]) <= step_of(k)), 1);
      prev_th[k] = th[k];
    end
  endtask

  task automatic send(input int k, input int c);
    cv[k] = 1'b1;
    cd[k] = 4'(c);
    tick();
    cv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    for (int i = 0; i < 60; i++) begin
      if (!cur_bz[k]) break;
      tick();
    end
    chk("idle_reached", k, int'(bz[k]), 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cv[k] = 1'b0;
      cd[k] = 4'd0;
      cur_lv[k] = 0;
      cur_bz[k] = 1'b0;
      cur_st[k] = 1'b0;
      prev_th[k] = '0;
    end

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Upward ramp 0->5, STEP=1
    send(0, 5);
    repeat (9) tick();

    // Equal code at level 5
    send(0, 5);
    repeat (4) tick();

    // Back-pressure: start 5->2, then hold code 9 valid while busy
    send(0, 2);
    cv[0] = 1'b1;
    cd[0] = 4'd9;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (acc[0]) break;
    end
    cv[0] = 1'b0;
    chk("bp_accepted", 0, int'(acc[0]), 1);
    chk("bp_accept_on_settled", 0, int'(acc_st[0]), 1);
    wait_idle(0);
    tick();

    // Clamped step, STEP=4: 0->15 then 15->2
    send(1, 15);
    wait_idle(1);
    chk("clamp_top", 1, int'(th[1]), 32'h7FFF);
    tick();
    send(1, 2);
    wait_idle(1);
    chk("clamp_bottom", 1, int'(lv[1]), 2);
    tick();

    // STEP=NLEVELS, SETTLE_CYCLES=0: 0->15
    send(2, 15);
    chk("full_step_busy", 2, int'(bz[2]), 1);
    tick();
    chk("full_step_level", 2, int'(lv[2]), 15);
    tick();
    chk("full_step_settled", 2, int'(st[2]), 1);
    tick();

    // Reset mid-op: 3->12, reset at level 6
    send(0, 3);
    wait_idle(0);
    tick();
    send(0, 12);
    for (int i = 0; i < 30; i++) begin
      if (cur_lv[0] == 6) break;
      tick();
    end
    chk("reached_6", 0, int'(lv[0]), 6);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_reset_ready", 0, int'(rdy[0]), 1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 3; k++) begin
        cv[k] = ($urandom_range(0, 3) == 0);
        cd[k] = 4'($urandom_range(0, 15));
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) cv[k] = 1'b0;
    for (int k = 0; k < 3; k++) wait_idle(k);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule : tb_therm_dac_driver
`default_nettype wire

// File: doc/therm_dac_driver.md
Name: therm_dac_driver

Overview:
- Binary-to-thermometer driver for the 4-bit current-steering DAC in the mixed-signal loop. It is the reverse direction of the flash-ADC thermometer-to-binary encoder.
- Accepts binary codes over a valid/ready handshake and drives a 15-line thermometer bus to the unary DAC cells.
- Slew-limits the bus to at most STEP levels per cycle, then holds for a settle window before signalling completion.

Parameters:
NBITS, 4, binary code width
NLEVELS, 2**NBITS-1 (15), thermometer width (derived, not overridable)
STEP, 1, max thermometer levels moved per clock; legal range 1..NLEVELS
SETTLE_CYCLES, 2, settle counter load value; legal range 0..255

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
code_valid  input  1  code is offered
code  input  NBITS  target binary code 0..NLEVELS
code_ready  output  1  block accepts a code this cycle
therm  output  NLEVELS  registered thermometer; therm[i]=1 iff level>=i+1
level  output  NBITS  registered binary value of current thermometer level
busy  output  1  high whenever state is not IDLE
settled  output  1  one-cycle pulse when target reached and settle window done

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values (any edge with rst=1, including mid-slew or mid-settle):
  - state=IDLE, level=0, therm=0, target=0, settle count=0, settled=0.
  - Any pending operation is discarded.
- code_ready = (state==IDLE) && !rst. A transfer occurs on an edge with code_valid && code_ready.
- States: IDLE, SLEW, SETTLE.
- IDLE, on a transfer:
  - target<=code.
  - If code!=level: go to SLEW.
  - If code==level: go directly to SETTLE, count<=SETTLE_CYCLES; therm is unchanged.
- SLEW, each edge:
  - diff=|target-level|.
  - level moves toward target by min(STEP,diff). The clamp means no overshoot.
  - When the new level==target: go to SETTLE, count<=SETTLE_CYCLES.
- SETTLE, each edge:
  - If count!=0: count<=count-1.
  - Else: go to IDLE with settled<=1.
  - Occupancy is SETTLE_CYCLES+1 cycles.
- settled is high exactly in the first IDLE cycle after SETTLE, and 0 in every other cycle.
  - A new transfer may occur in that same cycle.
- therm and level update on the same edge. therm is always the registered decode of the next level.
- Invariants:
  - therm is a valid thermometer every cycle (no 0 below a 1).
  - popcount(therm)==level.
  - Hamming distance between consecutive therm values is <=STEP.
- code_valid while not ready: ignored, no buffering; the source must hold it.
- Example (STEP=1, SETTLE_CYCLES=2): transfer at edge T0 from level 0 to 5.
  - level=1..5 after T1..T5; SETTLE entered at T5.
  - Count 2->1 at T6, 1->0 at T7; IDLE and settled=1 after T8.
  - Equal-code transfer at T0: settled after T3.
- Widths:
  - Differences are computed at NBITS+1 bits signed.
  - Step arithmetic saturates to 0..NLEVELS.

Decomposition:
- Package therm_dac_pkg holds:
  - NBITS and NLEVELS constants.
  - The state enum {IDLE,SLEW,SETTLE}.
  - The settle counter width (8).
- Sub-module bin2therm: purely combinational NBITS->NLEVELS decoder (therm[i]=(val>i)). It is instantiated on next-level, and its output is registered in the parent.
- The top holds the FSM, level/target registers, step clamp and settle counter.

Test Plan:
- Reset mid-op: start 3->12 (STEP=1), assert rst 2 cycles at level 6 -> after the first reset edge level=0, therm=0x0000, busy=0, settled=0; code_ready=0 while rst=1 and 1 the cycle after release.
- Upward ramp, STEP=1, SETTLE_CYCLES=2: code 5 from 0 -> therm 0x0001,0x0003,0x0007,0x000F,0x001F after T1..T5; settled pulse after T8; code_ready low T1..T8.
- Clamped step, STEP=4: 0->15 -> level 4,8,12,15, therm final 0x7FFF; then 15->2 -> levels 11,7,3,2, no overshoot.
- Equal code: level=5, send 5 -> therm stays 0x001F every cycle, busy 3 cycles, settled after T3.
- Back-pressure/back-to-back: hold code_valid=1 with code=9 during busy -> not accepted until the settled cycle; accepted there, and the next slew starts on the following edge.
- SETTLE_CYCLES=0, STEP=NLEVELS: 0->15 -> level=15 after T1, settled after T2; randomized run checks the thermometer invariant and popcount==level every cycle.
